// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline stage types, state encoding and EX/MEM payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] pc_four;
        logic [31:0] st_data;
        logic        br_sel;
        logic [31:0] alu_data;
        logic [3:0]  ld_op;
        logic        jump;
        logic        mem_wren;
        logic        is_load;
        logic [4:0]  rd_addr;
        logic        rd_wren;
    } ex_mem_bus_t;

    localparam int EX_MEM_W = 110;

    // Control bits that must read as 0 whenever the EX/MEM slot holds a bubble
    localparam ex_mem_bus_t EX_MEM_KILL_MASK = '{
        pc_four:  32'd0,
        st_data:  32'd0,
        br_sel:   1'b1,
        alu_data: 32'd0,
        ld_op:    4'd0,
        jump:     1'b1,
        mem_wren: 1'b1,
        is_load:  1'b1,
        rd_addr:  5'd0,
        rd_wren:  1'b1
    };

endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with one-entry skid buffer,
// flush with control-bit bubble masking and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = 110,
    parameter logic [DATA_W-1:0] KILL_MASK = '0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int              CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] s;
    logic              in_fire;
    logic              out_fire;

    // ready_o depends only on the state flop, so upstream sees no comb path
    assign valid_o  = state != PS_EMPTY;
    assign ready_o  = state != PS_FULL;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;
    assign data_o   = m;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= PS_EMPTY;
            m           <= RESET_VAL;
            s           <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (valid_o && !ready_i && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_i) begin
                state <= PS_EMPTY;
                m     <= m & ~KILL_MASK;
            end else begin
                case (state)
                    PS_EMPTY: if (in_fire) begin
                        m     <= data_i;
                        state <= PS_ONE;
                    end
                    PS_ONE: begin
                        if (in_fire && out_fire) m <= data_i;
                        else if (in_fire) begin
                            s     <= data_i;
                            state <= PS_FULL;
                        end else if (out_fire) begin
                            m     <= m & ~KILL_MASK;
                            state <= PS_EMPTY;
                        end
                    end
                    PS_FULL: if (ready_i) begin
                        m     <= s;
                        state <= PS_ONE;
                    end
                    default: state <= PS_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random stimulus checked against a queue-based
// reference model of the skid stage.
module tb_pipe_stage_skid;

    localparam int         DW   = 8;
    localparam logic [7:0] MASK = 8'h81;
    localparam logic [7:0] RV   = 8'h5A;
    localparam int         CW   = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_o;
    logic [CW-1:0] stall_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] last = RV;
    int         cnt = 0;

    pipe_stage_skid #(.DATA_W(DW), .KILL_MASK(MASK), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
        chk("ready_o", 32'(ready_o), 32'(q.size() < 2));
        chk("data_o", 32'(data_o), 32'(q.size() > 0 ? q[0] : last));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(cnt));
    endtask

    // One clock: apply inputs, advance the model with the values seen at the edge, compare
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        logic [7:0] tmp;
        bit of, inf;
        valid_i = v; data_i = d; ready_i = r; flush_i = f;
        @(posedge clk);
        if (q.size() > 0 && !r && cnt != 15) cnt++;
        if (f) begin
            if (q.size() > 0) last = q[0];
            last = last & ~MASK;
            q.delete();
        end else begin
            of  = q.size() > 0 && r;
            inf = v && q.size() < 2;
            if (of) begin
                tmp = q.pop_front();
                if (q.size() == 0 && !inf) last = tmp & ~MASK;
            end
            if (inf) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        q.delete(); last = RV; cnt = 0;
        chk("rst_data", 32'(data_o), 32'(RV));
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    initial begin
        do_reset();
        // streaming
        step(1, 8'h01, 1, 0);
        chk("stream_01", 32'(data_o), 32'h01);
        step(1, 8'h02, 1, 0);
        chk("stream_02", 32'(data_o), 32'h02);
        step(1, 8'h03, 1, 0);
        chk("stream_03", 32'(data_o), 32'h03);
        step(0, 8'h00, 1, 0);
        // skid
        step(1, 8'hFF, 0, 0);
        step(1, 8'h7E, 0, 0);
        chk("skid_ready_low", 32'(ready_o), 32'd0);
        chk("skid_hold_ff", 32'(data_o), 32'hFF);
        step(1, 8'h33, 0, 0);
        step(1, 8'h33, 1, 0);
        chk("skid_out_7e", 32'(data_o), 32'h7E);
        step(1, 8'h33, 1, 0);
        chk("skid_out_33", 32'(data_o), 32'h33);
        step(0, 8'h00, 1, 0);
        // flush from FULL, with a valid_i that must be dropped
        step(1, 8'hFF, 0, 0);
        step(1, 8'h7E, 0, 0);
        step(1, 8'hAA, 0, 1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_data", 32'(data_o), 32'h7E);
        chk("flush_ready", 32'(ready_o), 32'd1);
        step(0, 8'h00, 1, 0);
        // drain mask
        step(1, 8'h81, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("drain_data", 32'(data_o), 32'h00);
        // counter saturation
        do_reset();
        step(1, 8'h42, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0);
        chk("cnt_sat", 32'(stall_cnt_o), 32'hF);
        do_reset();
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
